// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: owns the PC, runs req/ack to instruction memory,
// presents one word per instruction to the decoder and traps misaligned redirects.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        nRst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        fault
);

  typedef enum logic [1:0] {FETCH, HOLD, FAULT} state_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_e      state_q, state_d;
  logic [31:0] fetch_addr_q, fetch_addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        instr_valid_q, instr_valid_d;
  logic        fault_q, fault_d;
  logic        mem_req_q, mem_req_d;

  always_comb begin
    state_d       = state_q;
    fetch_addr_d  = fetch_addr_q;
    instr_d       = instr_q;
    pc_d          = pc_q;
    instr_valid_d = instr_valid_q;
    fault_d       = fault_q;
    case (state_q)
      FETCH: begin
        // An ack only counts against a request we are actually driving, so an
        // ack left over from before reset is dropped on the first FETCH cycle.
        if (mem_req_q && mem_ack) begin
          instr_d       = mem_rdata;
          pc_d          = fetch_addr_q;
          instr_valid_d = 1'b1;
          state_d       = HOLD;
        end
      end
      HOLD: begin
        if (!stall) begin
          instr_valid_d = 1'b0;
          if (!branch_taken) begin
            fetch_addr_d = pc_q + PC_STEP;
            state_d      = FETCH;
          end else if (branch_target[1:0] != 2'b00) begin
            fault_d = 1'b1;
            state_d = FAULT;
          end else begin
            fetch_addr_d = branch_target;
            state_d      = FETCH;
          end
        end
      end
      FAULT:   state_d = FAULT;
      default: state_d = FAULT;
    endcase
  end

  // Request is registered from the next state, keeping inputs off mem_req/mem_addr.
  always_comb mem_req_d = (state_d == FETCH);

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q       <= FETCH;
      fetch_addr_q  <= RESET_PC;
      instr_q       <= NOP;
      pc_q          <= RESET_PC;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
      mem_req_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_addr_q  <= fetch_addr_d;
      instr_q       <= instr_d;
      pc_q          <= pc_d;
      instr_valid_q <= instr_valid_d;
      fault_q       <= fault_d;
      mem_req_q     <= mem_req_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = fetch_addr_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a program-order model predicts fetch
// addresses, a memory responder adds wait states, a monitor scores outputs.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          CYCLES   = 3000;

  logic        clk = 1'b0;
  logic        nRst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        fault;

  fetch_unit #(.RESET_PC(RESET_PC), .PC_STEP(32'd4)) dut (
    .clk(clk), .nRst(nRst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr(instr), .instr_valid(instr_valid), .pc(pc),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .fault(fault)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int captures = 0;

  // Model state: expected fetch addresses in program order.
  logic [31:0] exp_q[$];
  logic        model_fault = 1'b0;
  logic        consume_now = 1'b0;
  logic        exp_fault_q, exp_consumed_q;
  logic [31:0] last_addr;
  logic [31:0] cur_a = 32'h0;
  logic        prev_valid = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      exp_fault_q    <= 1'b0;
      exp_consumed_q <= 1'b0;
    end else begin
      exp_fault_q    <= model_fault;
      exp_consumed_q <= consume_now;
    end
  end

  // Memory responder: random wait states on real requests, garbage acks otherwise.
  initial begin
    int wcnt;
    wcnt = -1;
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!nRst || !mem_req) begin
        wcnt      = -1;
        mem_ack   = ($urandom_range(0, 7) == 0);
        mem_rdata = $urandom;
      end else begin
        if (wcnt < 0) wcnt = $urandom_range(0, 3);
        if (wcnt == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_word(mem_addr);
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = $urandom;
          wcnt--;
        end
      end
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (!nRst) begin
      prev_valid = 1'b0;
    end else begin
      if (mem_req) begin
        if (exp_q.size() == 0) chk("unexpected_req", {31'b0, mem_req}, 32'h0);
        else                   chk("mem_addr", mem_addr, exp_q[0]);
        chk("valid_during_fetch", {31'b0, instr_valid}, 32'h0);
      end
      if (exp_fault_q) begin
        chk("req_in_fault", {31'b0, mem_req}, 32'h0);
        chk("valid_in_fault", {31'b0, instr_valid}, 32'h0);
      end
      chk("fault", {31'b0, fault}, {31'b0, exp_fault_q});
      if (instr_valid && !prev_valid) begin
        if (exp_q.size() == 0) chk("unexpected_capture", {31'b0, instr_valid}, 32'h0);
        else begin
          cur_a = exp_q.pop_front();
          captures++;
        end
      end
      if (prev_valid && exp_consumed_q)  chk("valid_drop", {31'b0, instr_valid}, 32'h0);
      if (prev_valid && !exp_consumed_q) chk("valid_hold", {31'b0, instr_valid}, 32'h1);
      if (instr_valid) begin
        chk("pc", pc, cur_a);
        chk("instr", instr, mem_word(cur_a));
      end
      prev_valid = instr_valid;
    end
  end

  task automatic do_reset();
    nRst = 1'b0;
    stall = 1'b0;
    branch_taken = 1'b0;
    consume_now = 1'b0;
    #1;
    chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
    chk("rst_mem_addr", mem_addr, RESET_PC);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_pc", pc, RESET_PC);
    chk("rst_fault", {31'b0, fault}, 32'h0);
    exp_q.delete();
    exp_q.push_back(RESET_PC);
    last_addr   = RESET_PC;
    model_fault = 1'b0;
    repeat (2) @(negedge clk);
    nRst = 1'b1;
  endtask

  // Driver: decides stall/redirect against each valid instruction and
  // predicts the next fetch address from program order.
  initial begin
    int fault_cyc;
    int r;
    int pick;
    logic [31:0] tmp;
    fault_cyc = 0;
    nRst = 1'b0;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = 32'h0;
    last_addr = RESET_PC;
    @(negedge clk);
    do_reset();
    for (int cyc = 0; cyc < CYCLES; cyc++) begin
      @(negedge clk);
      consume_now   = 1'b0;
      stall         = $urandom_range(0, 1);
      branch_taken  = $urandom_range(0, 1);
      branch_target = $urandom;
      if (model_fault) begin
        fault_cyc++;
        if (fault_cyc > 5) begin
          fault_cyc = 0;
          do_reset();
        end
      end else if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else if (instr_valid) begin
        if ($urandom_range(0, 2) == 0) begin
          stall = 1'b1;
        end else begin
          stall = 1'b0;
          consume_now = 1'b1;
          r = $urandom_range(0, 15);
          if (r < 3) begin
            pick = $urandom_range(0, 2);
            tmp = $urandom;
            tmp[1:0] = 2'b00;
            if (pick == 0)      tmp = 32'h0000_0100;
            else if (pick == 1) tmp = 32'hFFFF_FFFC;
            branch_taken  = 1'b1;
            branch_target = tmp;
            last_addr     = tmp;
            exp_q.push_back(last_addr);
          end else if (r == 3 && $urandom_range(0, 3) == 0) begin
            tmp = $urandom;
            tmp[1:0] = 2'($urandom_range(1, 3));
            branch_taken  = 1'b1;
            branch_target = tmp;
            model_fault   = 1'b1;
          end else begin
            branch_taken = 1'b0;
            last_addr    = last_addr + 32'd4;
            exp_q.push_back(last_addr);
          end
        end
      end
    end
    @(negedge clk);
    chk("liveness", {31'b0, (captures >= 100)}, 32'h1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
